// File: rtl/lcd_pkg.sv
// Shared constants and types for the character-LCD front end: ASCII codes,
// the idle banner and the bounce-meter state encoding.
package lcd_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int TIME_DIGITS = 5;

    // Banner shown on the time field until the first measurement; 'R' is the MS byte.
    localparam logic [8*TIME_DIGITS-1:0] READY_STR = "Ready";

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        CONVERT,
        WAIT_RELEASE
    } meter_state_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one bit per clock,
// WIDTH shift cycles after go, then a one-cycle done pulse with bcd valid.
module bin2bcd_serial #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [WIDTH-1:0]      bin,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    r_bin;
    logic [DIGITS*4-1:0] r_bcd;
    logic [DIGITS*4-1:0] w_adj;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                r_cnt          <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (go) begin
                r_bin  <= bin;
                r_bcd  <= '0;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/bounce_meter.sv
// Push-button bounce meter: counts edges and first-to-last-edge milliseconds
// of one press, then publishes both as ASCII digits with a one-cycle start.
module bounce_meter
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES   = 50000,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic [7:0] fraction_tens,
    output logic [7:0] fraction_ones,
    output logic [7:0] time_vec1,
    output logic [7:0] time_vec2,
    output logic [7:0] time_vec3,
    output logic [7:0] time_vec4,
    output logic [7:0] time_vec5,
    output logic       start,
    output logic       busy
);

    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [16:0]   MS_MAX      = 17'd99999;
    localparam logic [6:0]    EDGE_MAX    = 7'd99;

    logic r_sync1, r_btn_s, r_btn_p;

    meter_state_t r_state, w_next;
    logic         w_publish;

    logic [TW-1:0] r_tick_cnt;
    logic [16:0]   r_ms_cnt;
    logic [16:0]   r_last_ms;
    logic [6:0]    r_edge_cnt;
    logic [SW-1:0] r_stable_cnt;
    logic          r_conv_go;

    logic                     w_edge;
    logic                     w_stable_done;
    logic                     w_ms_done, w_cnt_done, w_conv_done;
    logic [TIME_DIGITS*4-1:0] w_ms_bcd;
    logic [7:0]               w_cnt_bcd;

    logic [7:0] r_frac_tens, r_frac_ones;
    logic [7:0] r_tv1, r_tv2, r_tv3, r_tv4, r_tv5;
    logic       r_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_btn_s <= 1'b1;
            r_btn_p <= 1'b1;
        end else begin
            r_sync1 <= btn_raw;
            r_btn_s <= r_sync1;
            r_btn_p <= r_btn_s;
        end
    end

    assign w_edge        = (r_btn_s != r_btn_p);
    assign w_stable_done = (r_stable_cnt == STABLE_LAST) && !w_edge;
    assign w_conv_done   = w_ms_done && w_cnt_done;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_publish = 1'b0;
        case (r_state)
            IDLE:         if (!r_btn_s) w_next = MEASURE;
            MEASURE:      if (w_stable_done) w_next = r_btn_s ? IDLE : CONVERT;
            CONVERT: begin
                if (w_conv_done) begin
                    w_publish = 1'b1;
                    w_next    = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: if (w_stable_done && r_btn_s) w_next = IDLE;
            default:      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_ms_cnt     <= '0;
            r_last_ms    <= '0;
            r_edge_cnt   <= '0;
            r_stable_cnt <= '0;
            r_conv_go    <= 1'b0;
        end else begin
            r_conv_go <= (r_state == MEASURE) && (w_next == CONVERT);
            case (r_state)
                IDLE: begin
                    // The falling edge that wakes us is the first counted edge.
                    if (w_next == MEASURE) begin
                        r_edge_cnt   <= 7'd1;
                        r_ms_cnt     <= '0;
                        r_last_ms    <= '0;
                        r_stable_cnt <= '0;
                        r_tick_cnt   <= '0;
                    end
                end
                MEASURE: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= '0;
                        if (r_ms_cnt != MS_MAX) r_ms_cnt <= r_ms_cnt + 17'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                    if (w_edge) begin
                        if (r_edge_cnt != EDGE_MAX) r_edge_cnt <= r_edge_cnt + 7'd1;
                        r_last_ms    <= r_ms_cnt;
                        r_stable_cnt <= '0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + SW'(1);
                    end
                end
                CONVERT: begin
                    if (w_next == WAIT_RELEASE) r_stable_cnt <= '0;
                end
                WAIT_RELEASE: begin
                    // Only a quiet, released button advances the release timer.
                    if (!r_btn_s || w_edge) r_stable_cnt <= '0;
                    else                    r_stable_cnt <= r_stable_cnt + SW'(1);
                end
                default: ;
            endcase
        end
    end

    bin2bcd_serial #(
        .WIDTH  (17),
        .DIGITS (TIME_DIGITS)
    ) u_ms_conv (
        .clk  (clk),
        .rst  (rst),
        .go   (r_conv_go),
        .bin  (r_last_ms),
        .bcd  (w_ms_bcd),
        .done (w_ms_done)
    );

    // Count never exceeds 99, so two digits suffice; same width keeps both done together.
    bin2bcd_serial #(
        .WIDTH  (17),
        .DIGITS (2)
    ) u_cnt_conv (
        .clk  (clk),
        .rst  (rst),
        .go   (r_conv_go),
        .bin  ({10'd0, r_edge_cnt}),
        .bcd  (w_cnt_bcd),
        .done (w_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frac_tens <= ASCII_SPACE;
            r_frac_ones <= ASCII_ZERO;
            r_tv1       <= READY_STR[39:32];
            r_tv2       <= READY_STR[31:24];
            r_tv3       <= READY_STR[23:16];
            r_tv4       <= READY_STR[15:8];
            r_tv5       <= READY_STR[7:0];
            r_start     <= 1'b0;
        end else begin
            r_start <= w_publish;
            if (w_publish) begin
                r_frac_tens <= bcd_to_ascii(w_cnt_bcd[7:4]);
                r_frac_ones <= bcd_to_ascii(w_cnt_bcd[3:0]);
                r_tv1       <= bcd_to_ascii(w_ms_bcd[19:16]);
                r_tv2       <= bcd_to_ascii(w_ms_bcd[15:12]);
                r_tv3       <= bcd_to_ascii(w_ms_bcd[11:8]);
                r_tv4       <= bcd_to_ascii(w_ms_bcd[7:4]);
                r_tv5       <= bcd_to_ascii(w_ms_bcd[3:0]);
            end
        end
    end

    assign fraction_tens = r_frac_tens;
    assign fraction_ones = r_frac_ones;
    assign time_vec1     = r_tv1;
    assign time_vec2     = r_tv2;
    assign time_vec3     = r_tv3;
    assign time_vec4     = r_tv4;
    assign time_vec5     = r_tv5;
    assign start         = r_start;
    assign busy          = (r_state != IDLE);

endmodule
